// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: tracks predictions through IF/ID and ID/EX, compares
// them against the EX outcome, and issues a one-cycle flush with the corrected PC.
module branch_resolve_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pipe_en,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_taken,
  input  logic [31:0]      if_pred_pc,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic [31:0]      update_pc,
  output logic [31:0]      branch_target,
  output logic             branch_flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } trk_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  trk_t             s1_q, s1_d;
  trk_t             s2_q, s2_d;
  logic [31:0]      update_pc_q, update_pc_d;
  logic [31:0]      branch_target_q, branch_target_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             branch_flush_q, branch_flush_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  logic             resolve;
  logic             mispredict;
  logic [31:0]      fix_pc;

  // Resolution looks at S2 as it stands before this cycle's advance.
  always_comb begin
    resolve    = (state_q == RUN) && pipe_en && ex_branch && s2_q.valid;
    mispredict = 1'b0;
    if (resolve) begin
      if (ex_taken != s2_q.pred_taken) begin
        mispredict = 1'b1;
      end else if (ex_taken && (ex_target != s2_q.pred_pc)) begin
        mispredict = 1'b1;
      end
    end
    fix_pc = ex_taken ? ex_target : (s2_q.pc + 32'd4);
  end

  always_comb begin
    state_d         = state_q;
    s1_d            = s1_q;
    s2_d            = s2_q;
    update_pc_d     = update_pc_q;
    branch_target_d = branch_target_q;
    redirect_pc_d   = redirect_pc_q;
    branch_flush_d  = 1'b0;
    br_count_d      = br_count_q;
    mp_count_d      = mp_count_q;

    case (state_q)
      RUN: begin
        if (pipe_en) begin
          s2_d = s1_q;
          s1_d = '{valid: if_valid, pc: if_pc, pred_taken: if_pred_taken,
                   pred_pc: if_pred_pc};
        end
        if (resolve && (br_count_q != CNT_MAX)) begin
          br_count_d = br_count_q + CNT_W'(1);
        end
        if (mispredict) begin
          if (mp_count_q != CNT_MAX) begin
            mp_count_d = mp_count_q + CNT_W'(1);
          end
          update_pc_d     = s2_q.pc;
          branch_target_d = fix_pc;
          redirect_pc_d   = fix_pc;
          branch_flush_d  = 1'b1;
          state_d         = FLUSH;
        end
      end
      FLUSH: begin
        // Wrong-path entries are squashed; all inputs are ignored this cycle.
        s1_d.valid = 1'b0;
        s2_d.valid = 1'b0;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= RUN;
      s1_q            <= '0;
      s2_q            <= '0;
      update_pc_q     <= '0;
      branch_target_q <= '0;
      redirect_pc_q   <= '0;
      branch_flush_q  <= 1'b0;
      br_count_q      <= '0;
      mp_count_q      <= '0;
    end else begin
      state_q         <= state_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      update_pc_q     <= update_pc_d;
      branch_target_q <= branch_target_d;
      redirect_pc_q   <= redirect_pc_d;
      branch_flush_q  <= branch_flush_d;
      br_count_q      <= br_count_d;
      mp_count_q      <= mp_count_d;
    end
  end

  assign update_pc     = update_pc_q;
  assign branch_target = branch_target_q;
  assign redirect_pc   = redirect_pc_q;
  assign branch_flush  = branch_flush_q;
  assign br_count      = br_count_q;
  assign mp_count      = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push expected
// flush records; a monitor pops and compares on every branch_flush cycle.
module tb_branch_resolve_unit;

  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          pipe_en, if_valid, if_pred_taken, ex_branch, ex_taken;
  logic [31:0]   if_pc, if_pred_pc, ex_target;
  logic [31:0]   update_pc, branch_target, redirect_pc;
  logic          branch_flush;
  logic [CW-1:0] br_count, mp_count;

  typedef struct {
    logic [31:0] upd;
    logic [31:0] redir;
  } flush_rec_t;

  flush_rec_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .pipe_en(pipe_en),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_pred_pc(if_pred_pc),
    .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .update_pc(update_pc), .branch_target(branch_target),
    .branch_flush(branch_flush), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every flush cycle must match the oldest expected record.
  always @(posedge CLK) begin
    #1;
    if (branch_flush === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flush actual=1 required=0");
      end else begin
        flush_rec_t r;
        r = sb.pop_front();
        chk("flush_update_pc", update_pc, r.upd);
        chk("flush_branch_target", branch_target, r.redir);
        chk("flush_redirect_pc", redirect_pc, r.redir);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_br"}, 32'(br_count), 32'(exp_br));
    chk({tag, "_mp"}, 32'(mp_count), 32'(exp_mp));
  endtask

  task automatic idle();
    pipe_en = 1'b1; if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0;
    if_pred_pc = '0; ex_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
  endtask

  // Fetch one branch, walk it to EX and resolve it. During the two walk cycles
  // ex_branch is driven with a would-be mispredict: S2 is invalid, so nothing
  // may resolve. After a flush, inputs are driven during FLUSH and for two
  // more cycles to show they were ignored and the tracker was squashed.
  task automatic fetch_branch(input logic [31:0] pc, input logic pt, input logic [31:0] ppc,
                              input logic tk, input logic [31:0] tgt,
                              input logic is_mp, input logic [31:0] redir,
                              input logic rst_in_flush);
    idle();
    if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_pc = ppc;
    ex_branch = 1'b1; ex_taken = ~pt; ex_target = 32'hbad0;
    step();
    if_valid = 1'b0;
    step();
    chk_counts("no_resolve_s2_invalid");
    ex_branch = 1'b1; ex_taken = tk; ex_target = tgt;
    if (is_mp) sb.push_back('{upd: pc, redir: redir});
    step();
    exp_br = (exp_br == 15) ? 15 : exp_br + 1;
    if (is_mp) exp_mp = (exp_mp == 15) ? 15 : exp_mp + 1;
    chk_counts("resolve");
    if (is_mp && rst_in_flush) begin
      #1;
      RST = 1'b1;
      #1;
      chk("rst_mid_flush_flag", 32'(branch_flush), 32'd0);
      chk("rst_mid_flush_br", 32'(br_count), 32'd0);
      chk("rst_mid_flush_mp", 32'(mp_count), 32'd0);
      chk("rst_mid_flush_redirect", redirect_pc, 32'd0);
      exp_br = 0;
      exp_mp = 0;
      RST = 1'b0;
      idle();
      step();
    end else if (is_mp) begin
      if_valid = 1'b1; if_pc = 32'hdead0000; if_pred_taken = 1'b0;
      ex_branch = 1'b1; ex_taken = ~tk; ex_target = 32'h1234;
      step();
      chk_counts("flush_cycle_ignored");
      idle();
      ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h4444;
      step();
      step();
      chk_counts("tracker_squashed");
    end
    idle();
  endtask

  initial begin
    idle();
    RST = 1'b1;
    #12;
    chk("reset_flush", 32'(branch_flush), 32'd0);
    chk("reset_update_pc", update_pc, 32'd0);
    chk("reset_branch_target", branch_target, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk_counts("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Correct not-taken.
    fetch_branch(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
    // Predicted not-taken, actually taken.
    fetch_branch(32'h200, 1'b0, 32'h0,   1'b1, 32'h400, 1'b1, 32'h400, 1'b0);
    // Taken with wrong target.
    fetch_branch(32'h300, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h600, 1'b0);
    // Predicted taken, actually not taken: fall-through.
    fetch_branch(32'h300, 1'b1, 32'h500, 1'b0, 32'h0,   1'b1, 32'h304, 1'b0);
    // Correct not-taken with mismatching pred_pc/ex_target.
    fetch_branch(32'h380, 1'b0, 32'h999, 1'b0, 32'h123, 1'b0, 32'h0,   1'b0);
    chk("hold_redirect_pc", redirect_pc, 32'h304);
    chk("hold_update_pc", update_pc, 32'h300);
    // Correct taken with matching target.
    fetch_branch(32'h3c0, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h0,   1'b0);
    // Fall-through wraps modulo 2^32.
    fetch_branch(32'hfffffffc, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

    // Mispredict presented with pipe_en=0 waits for the next enabled cycle.
    idle();
    if_valid = 1'b1; if_pc = 32'h700;
    step();
    if_valid = 1'b0;
    step();
    pipe_en = 1'b0; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h800;
    step();
    step();
    chk_counts("stall_no_resolve");
    sb.push_back('{upd: 32'h700, redir: 32'h800});
    pipe_en = 1'b1;
    step();
    exp_br++;
    exp_mp++;
    chk_counts("stall_then_resolve");
    idle();
    step();
    step();

    // Saturation with a 4-bit counter, then reset during a flush.
    RST = 1'b1;
    #1;
    exp_br = 0;
    exp_mp = 0;
    chk_counts("second_reset");
    RST = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fetch_branch(32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    end
    chk("br_saturated", 32'(br_count), 32'd15);
    fetch_branch(32'h2000, 1'b0, 32'h0, 1'b1, 32'h2400, 1'b1, 32'h2400, 1'b1);
    step();
    step();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
